// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU width, opcode map and sequencer states.
package alu_pkg;

  localparam int unsigned ALU_DW = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL1 = 4'b0110;
  localparam logic [3:0] OP_SHR1 = 4'b0111;
  localparam logic [3:0] OP_ROL  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } seq_state_e;

  // Opcodes are contiguous from ADD to ROR; everything above is unsupported.
  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module alu_cmd_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers and empty flag guard it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time through registered ALU inputs and returns
// each captured result over a valid/ready response port, with optional accumulator chaining.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DW    = ALU_DW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  input  logic            cmd_chain,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [3:0]      alu_sel,
  input  logic [DW-1:0]   alu_res,
  input  logic            alu_carry,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DW-1:0]   resp_res,
  output logic            resp_carry,
  output logic            resp_zero,
  output logic            resp_err,
  output logic [CNTW-1:0] resp_count
);

  localparam int unsigned CmdW = 2 * DW + 5;

  logic [CmdW-1:0] fifo_wdata, fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic            head_chain;
  logic [3:0]      head_op;
  logic [DW-1:0]   head_a, head_b;

  seq_state_e      state_q, state_d;
  logic [DW-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            err_q, err_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_res_q, resp_res_d;
  logic            resp_carry_q, resp_carry_d;
  logic            resp_zero_q, resp_zero_d;
  logic            resp_err_q, resp_err_d;
  logic [CNTW-1:0] resp_count_q, resp_count_d;

  assign fifo_wdata = {cmd_chain, cmd_op, cmd_a, cmd_b};
  assign head_chain = fifo_rdata[CmdW-1];
  assign head_op    = fifo_rdata[2*DW +: 4];
  assign head_a     = fifo_rdata[DW +: DW];
  assign head_b     = fifo_rdata[0 +: DW];

  alu_cmd_fifo #(
    .DW    (CmdW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready = !fifo_full;

  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    err_d        = err_q;
    acc_d        = acc_q;
    resp_valid_d = resp_valid_q;
    resp_res_d   = resp_res_q;
    resp_carry_d = resp_carry_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;
    resp_count_d = resp_count_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_a_d  = head_chain ? acc_q : head_a;
          alu_b_d  = head_b;
          // Unsupported opcodes still take an EXEC slot so responses stay in order.
          if (is_valid_op(head_op)) begin
            alu_sel_d = head_op;
            err_d     = 1'b0;
          end else begin
            alu_sel_d = OP_ADD;
            err_d     = 1'b1;
          end
          state_d = StExec;
        end
      end
      StExec: begin
        resp_valid_d = 1'b1;
        state_d      = StResp;
        if (err_q) begin
          resp_res_d   = '0;
          resp_carry_d = 1'b0;
          resp_zero_d  = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          resp_res_d   = alu_res;
          resp_carry_d = alu_carry;
          resp_zero_d  = (alu_res == '0);
          resp_err_d   = 1'b0;
          acc_d        = alu_res;
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_count_d = resp_count_q + CNTW'(1);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      err_q        <= 1'b0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_res_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_count_q <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
      resp_valid_q <= resp_valid_d;
      resp_res_q   <= resp_res_d;
      resp_carry_q <= resp_carry_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
      resp_count_q <= resp_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_res   = resp_res_q;
  assign resp_carry = resp_carry_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;
  assign resp_count = resp_count_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential requester that drives the existing combinational 8-bit ALU (operands A/B, 4-bit ALU_Sel; returns res, carry).
- Accepts commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU through registered outputs, captures the result, and returns it over a valid/ready response interface.
- Supports an accumulate (chain) mode and flags unsupported opcodes; replaces the free-running stimulus style of driving the ALU directly.

Parameters:
- DW, 8, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO depth; power of 2, >= 2.
- CNTW, 16, width of the completed-response counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full, registered.
- cmd_op  in  4  ALU opcode.
- cmd_a  in  DW  operand A.
- cmd_b  in  DW  operand B.
- cmd_chain  in  1  1 = use the accumulator in place of cmd_a.
- alu_a  out  DW  to ALU A.
- alu_b  out  DW  to ALU B.
- alu_sel  out  4  to ALU ALU_Sel.
- alu_res  in  DW  from ALU res.
- alu_carry  in  1  from ALU carry.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_res  out  DW  captured result.
- resp_carry  out  1  captured carry.
- resp_zero  out  1  resp_res == 0.
- resp_err  out  1  unsupported opcode.
- resp_count  out  CNTW  number of responses handed off; wraps modulo 2^CNTW.

Behaviour:
- Reset (async assert, sync-deassert usage):
  - FIFO emptied; state IDLE.
  - alu_a, alu_b, alu_sel = 0.
  - resp_* = 0, resp_valid = 0, cmd_ready = 1.
  - Accumulator = 0, resp_count = 0.
  - Reset mid-operation discards all queued and in-flight commands; no response is emitted for them.
- Command accept: push when cmd_valid && cmd_ready at a rising edge. cmd_ready is computed from the registered FIFO full status only. A pop in the same cycle does not raise cmd_ready until the next cycle.
- Opcodes:
  - Supported: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SHL1, 0111 SHR1, 1000 ROL1, 1001 ROR1.
  - 1010..1111 are unsupported.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO not empty, pop and register the head into alu_a/alu_b/alu_sel, then go to EXEC. alu_a = accumulator if chain=1, else cmd_a. For an unsupported opcode, still go to EXEC but drive alu_sel = 0000 and latch err = 1.
  - EXEC: ALU inputs have been stable a full cycle. At the edge, capture alu_res and alu_carry into resp_res/resp_carry, set resp_zero, set resp_valid = 1, go to RESP.
    - If err: resp_res = 0, resp_carry = 0, resp_zero = 1, resp_err = 1.
    - If no err, the accumulator is updated to alu_res. An erroring command leaves the accumulator unchanged.
  - RESP: hold all resp_* stable while resp_valid && !resp_ready. On resp_ready: resp_valid = 0, resp_count += 1, go to IDLE.
- Latency: a command pushed at edge N is issued at N+1 if the FSM is IDLE and the FIFO was empty. Result is captured at N+2, so resp_valid = 1 in the cycle after edge N+2. Peak throughput is one command per 3 cycles.
- ALU-side outputs hold their last value outside EXEC; the ALU is purely combinational, so this is harmless.
- Capacity: DEPTH entries in the FIFO plus one in flight. cmd_valid while cmd_ready = 0 is ignored; the producer must hold its command.
- Chain on the first command after reset uses accumulator = 0.

Decomposition:
- Package alu_pkg holds:
  - ALU_DW = 8.
  - Opcode localparams OP_ADD..OP_ROR (0000..1001).
  - Function is_valid_op(op).
- One sub-module, alu_cmd_fifo: synchronous FIFO with parameters DW, DEPTH and registered full/empty. The FSM, accumulator, response register and counter stay in the top level.

Test Plan:
- Push ADD A=25 B=17, resp_ready=1 -> resp_res=42, carry=0, zero=0, err=0; resp_valid asserted 2 edges after accept; resp_count=1.
- Push ADD A=240 B=31 -> resp_res=15, carry=1. Then SUB A=50 B=30 -> 20, carry=0.
- Chain: SUB 50-30, then ADD chain=1 B=5 -> 25. Then bad op 1111 chain=1 -> err=1, res=0, zero=1. Then ADD chain=1 B=1 -> 26, confirming the accumulator was unchanged by the error.
- Backpressure: resp_ready=0, push 7 commands back-to-back -> 5 accepted (1 in flight + 4 queued), cmd_ready low afterwards. Release resp_ready -> 5 responses in push order, with res values matching the reference ALU model.
- Bitwise/shift sweep: AND 0xAA,0xCC -> 0x88; XOR 0xF0,0x0F -> 0xFF; NOT 0xD5 -> 0x2A; ROL 0x81 -> 0x03; ROR 0x81 -> 0xC0.
- Assert rst_n low while in EXEC with 2 queued -> all outputs immediately at reset values. After release, no stale responses appear; cmd_ready=1, resp_count=0.
